parking_gate_controller: RTL
============================

Name: parking_gate_controller

Overview:
Sequential controller for the 8-space parking lot. It arbitrates car entry and exit requests and owns the occupancy register. Each accepted entry is given the lowest-numbered free space; exits release their space. The block drives the entry and exit gates through timed open phases, with a 4-phase req/ack handshake to the gate sensors.

Parameters:
GATE_CYCLES, 4, clock cycles a gate stays open per transaction (legal range 1..255)
INIT_OCCUPANCY, 8'h00, occupancy value loaded at reset (bit i = 1 means space i occupied)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
entry_req  input  1  car at entry gate; held high until entry_ack seen, then dropped
exit_req  input  1  car at exit gate; held high until exit_ack seen, then dropped
exit_space  input  3  space number being vacated, valid while exit_req high
entry_ack  output  1  entry transaction complete; high until entry_req falls
exit_ack  output  1  exit transaction complete; high until exit_req falls
entry_reject  output  1  qualifies entry_ack: lot full, no space assigned
exit_err  output  1  qualifies exit_ack: exit_space was not occupied
park_number  output  3  space assigned to last accepted entry; holds until next accepted entry
entry_gate  output  1  entry gate open
exit_gate  output  1  exit gate open
occupancy  output  8  current occupancy register
free_count  output  4  number of zero bits in occupancy (0..8), registered
full  output  1  occupancy == 8'hFF

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; occupancy = INIT_OCCUPANCY; free_count = popcount(~INIT_OCCUPANCY); full set accordingly.
  - All other outputs 0, including park_number = 0.
  - Reset mid-transaction aborts it: gate closes immediately, no ack is issued, occupancy reverts to INIT_OCCUPANCY.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN, ENTRY_ACK, EXIT_ACK.
- IDLE arbitration: exit has fixed priority over entry, because an exit frees capacity.
- IDLE, exit_req=1:
  - occupancy[exit_space]=1: clear that bit at the transition edge, load timer, go to EXIT_OPEN.
  - occupancy[exit_space]=0: go to EXIT_ACK with exit_err=1; no gate opens.
- IDLE, entry_req=1, no exit_req:
  - full=0: at the transition edge, park_number = lowest index i with occupancy[i]=0 and occupancy[i] is set; load timer; go to ENTRY_OPEN.
  - full=1: go to ENTRY_ACK with entry_reject=1; park_number unchanged.
- ENTRY_OPEN / EXIT_OPEN:
  - The respective gate is high for exactly GATE_CYCLES cycles.
  - Timer counts down; at 1, go to the matching ACK state.
- ENTRY_ACK / EXIT_ACK:
  - ack high while the matching req is high.
  - When req is sampled low: ack, entry_reject and exit_err clear on that edge; return to IDLE.
- Latency:
  - Accepted request to ack: GATE_CYCLES+1 cycles from the IDLE sampling edge.
  - Rejected or error request: ack 1 cycle after sampling.
- No new transaction starts until the current handshake closes. A request held during another transaction is served on return to IDLE.
- free_count and full are registered and update on the same edge as occupancy.
- A request that drops before its ack is not cancelled; the transaction completes and the ack pulses for one cycle.

Optional Feature:
PARK_STATS_EN
- Defined: adds output total_entries[15:0] and output total_rejects[15:0].
  - Reset to 0.
  - total_entries increments on each accepted entry, total_rejects on each full-lot reject.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package parking_pkg holds:
  - state enum (5 states)
  - NUM_SPACES=8
  - SPACE_W=3
  - COUNT_W=4
- One sub-module: free_space_finder. It is combinational: from an 8-bit occupancy it gives the lowest free index (3b) plus a found flag. Reuse it anywhere space assignment is needed.

Test Plan:
1. Reset with INIT_OCCUPANCY=8'h00, then entry_req held until ack -> park_number=0, occupancy=8'h01, entry_gate high exactly 4 cycles, entry_ack at cycle 5, free_count=7.
2. occupancy=8'h0B, entry -> park_number=2, occupancy=8'h0F; then exit_req with exit_space=1 -> occupancy=8'h0D, exit_gate high 4 cycles, exit_err=0.
3. occupancy=8'hFF, entry_req -> entry_ack with entry_reject=1 one cycle after sampling, no gate, park_number unchanged, full=1.
4. entry_req and exit_req (exit_space=3, occupied) rise on the same cycle -> exit served first; entry served after the exit handshake closes.
5. exit_req with exit_space=5 on occupancy=8'h01 -> exit_ack with exit_err=1, occupancy unchanged, exit_gate never high.
6. rst_n pulled low during ENTRY_OPEN cycle 2 -> entry_gate=0 immediately, occupancy=INIT_OCCUPANCY, no ack; with PARK_STATS_EN, counters=0.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and sizing for the parking gate controller.
// Used by parking_gate_controller and free_space_finder.
package parking_pkg;

    localparam int unsigned NUM_SPACES = 8;
    localparam int unsigned SPACE_W    = 3;
    localparam int unsigned COUNT_W    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StEntryOpen,
        StExitOpen,
        StEntryAck,
        StExitAck
    } gate_state_e;

    function automatic logic [COUNT_W-1:0] count_free(input logic [NUM_SPACES-1:0] occ);
        logic [COUNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SPACES; i++) begin
            if (!occ[i]) cnt = cnt + COUNT_W'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/free_space_finder.sv
// Combinational search for the lowest-numbered free space in an occupancy map.
module free_space_finder
    import parking_pkg::*;
(
    input  logic [NUM_SPACES-1:0] occupancy,
    output logic [SPACE_W-1:0]    free_index,
    output logic                  found
);

    // Scan from the top so the lowest free index is the last one written.
    always_comb begin
        free_index = '0;
        found      = 1'b0;
        for (int i = NUM_SPACES - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                free_index = SPACE_W'(i);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit gate sequencer and occupancy owner for the 8-space lot.
// Optional macro PARK_STATS_EN adds saturating entry/reject counters.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned          GATE_CYCLES    = 4,
    parameter logic [NUM_SPACES-1:0] INIT_OCCUPANCY = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  entry_req,
    input  logic                  exit_req,
    input  logic [SPACE_W-1:0]    exit_space,
    output logic                  entry_ack,
    output logic                  exit_ack,
    output logic                  entry_reject,
    output logic                  exit_err,
    output logic [SPACE_W-1:0]    park_number,
    output logic                  entry_gate,
    output logic                  exit_gate,
    output logic [NUM_SPACES-1:0] occupancy,
    output logic [COUNT_W-1:0]    free_count,
    output logic                  full
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]           total_entries,
    output logic [15:0]           total_rejects
`endif
);

    gate_state_e           state_q, state_d;
    logic [NUM_SPACES-1:0] occupancy_q, occupancy_d;
    logic [COUNT_W-1:0]    free_count_q, free_count_d;
    logic                  full_q, full_d;
    logic [SPACE_W-1:0]    park_number_q, park_number_d;
    logic [7:0]            timer_q, timer_d;
    logic                  entry_reject_q, entry_reject_d;
    logic                  exit_err_q, exit_err_d;

    logic [SPACE_W-1:0]    free_index;
    logic                  free_found;

    free_space_finder u_finder (
        .occupancy  (occupancy_q),
        .free_index (free_index),
        .found      (free_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            occupancy_q    <= INIT_OCCUPANCY;
            free_count_q   <= count_free(INIT_OCCUPANCY);
            full_q         <= &INIT_OCCUPANCY;
            park_number_q  <= '0;
            timer_q        <= '0;
            entry_reject_q <= 1'b0;
            exit_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            occupancy_q    <= occupancy_d;
            free_count_q   <= free_count_d;
            full_q         <= full_d;
            park_number_q  <= park_number_d;
            timer_q        <= timer_d;
            entry_reject_q <= entry_reject_d;
            exit_err_q     <= exit_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        occupancy_d    = occupancy_q;
        park_number_d  = park_number_q;
        timer_d        = timer_q;
        entry_reject_d = entry_reject_q;
        exit_err_d     = exit_err_q;

        unique case (state_q)
            StIdle: begin
                // Exit wins a tie: it frees capacity the waiting entry may need.
                if (exit_req) begin
                    if (occupancy_q[exit_space]) begin
                        occupancy_d[exit_space] = 1'b0;
                        timer_d                 = 8'(GATE_CYCLES);
                        state_d                 = StExitOpen;
                    end else begin
                        exit_err_d = 1'b1;
                        state_d    = StExitAck;
                    end
                end else if (entry_req) begin
                    if (free_found) begin
                        occupancy_d[free_index] = 1'b1;
                        park_number_d           = free_index;
                        timer_d                 = 8'(GATE_CYCLES);
                        state_d                 = StEntryOpen;
                    end else begin
                        entry_reject_d = 1'b1;
                        state_d        = StEntryAck;
                    end
                end
            end
            StEntryOpen: begin
                if (timer_q == 8'd1) state_d = StEntryAck;
                else                 timer_d = timer_q - 8'd1;
            end
            StExitOpen: begin
                if (timer_q == 8'd1) state_d = StExitAck;
                else                 timer_d = timer_q - 8'd1;
            end
            StEntryAck: begin
                if (!entry_req) begin
                    entry_reject_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            StExitAck: begin
                if (!exit_req) begin
                    exit_err_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        free_count_d = count_free(occupancy_d);
        full_d       = &occupancy_d;
    end

    assign entry_ack    = (state_q == StEntryAck);
    assign exit_ack     = (state_q == StExitAck);
    assign entry_gate   = (state_q == StEntryOpen);
    assign exit_gate    = (state_q == StExitOpen);
    assign entry_reject = entry_reject_q;
    assign exit_err     = exit_err_q;
    assign park_number  = park_number_q;
    assign occupancy    = occupancy_q;
    assign free_count   = free_count_q;
    assign full         = full_q;

`ifdef PARK_STATS_EN
    logic        entry_accepted, entry_rejected;
    logic [15:0] entries_q, rejects_q;

    assign entry_accepted = (state_q == StIdle) && (state_d == StEntryOpen);
    assign entry_rejected = (state_q == StIdle) && (state_d == StEntryAck);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            rejects_q <= '0;
        end else begin
            if (entry_accepted && (entries_q != 16'hFFFF)) entries_q <= entries_q + 16'd1;
            if (entry_rejected && (rejects_q != 16'hFFFF)) rejects_q <= rejects_q + 16'd1;
        end
    end

    assign total_entries = entries_q;
    assign total_rejects = rejects_q;
`endif

endmodule
